// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of a single-command SDRAM controller.
// Each port owns one pending slot; the FSM issues one command at a time.
module sdram_arbiter #(
    parameter int unsigned PRIORITY_MODE  = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] p0_a,
    input  logic [31:0] p0_d,
    input  logic        p0_rd,
    input  logic        p0_we,
    output logic [31:0] p0_spo,
    output logic        p0_ready,
    input  logic [31:0] p1_a,
    input  logic [31:0] p1_d,
    input  logic        p1_rd,
    input  logic        p1_we,
    output logic [31:0] p1_spo,
    output logic        p1_ready,
    output logic [31:0] m_a,
    output logic [31:0] m_d,
    output logic        m_rd,
    output logic        m_we,
    input  logic [31:0] m_spo,
    input  logic        m_ready,
    output logic        grant,
    output logic        err_timeout
);

    localparam int unsigned CLOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W  = (CLOG_W > 10) ? CLOG_W : 10;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_d;
    logic             start_c;
    logic             done_c;
    logic             contested_c;
    logic             win_c;
    logic             rr_last;
    logic             wait_first;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_inc;

    logic             p0_pend_rd;
    logic [31:0]      p0_pend_a;
    logic [31:0]      p0_pend_d;
    logic             p1_pend_rd;
    logic [31:0]      p1_pend_a;
    logic [31:0]      p1_pend_d;

    assign wait_cnt_inc = wait_cnt + CNT_W'(1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and arbitration; the round-robin pointer only moves on contested grants
    always_comb begin
        state_d     = state;
        start_c     = 1'b0;
        done_c      = 1'b0;
        contested_c = 1'b0;
        win_c       = grant;
        case (state)
            IDLE: begin
                if ((!p0_ready || !p1_ready) && m_ready) begin
                    start_c = 1'b1;
                    state_d = ISSUE;
                    if (!p0_ready && !p1_ready) begin
                        contested_c = 1'b1;
                        win_c       = (PRIORITY_MODE == 1) ? 1'b0 : !rr_last;
                    end else begin
                        win_c = p0_ready;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (!wait_first && m_ready) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending slots, command outputs, read data and timeout tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_ready    <= 1'b1;
            p1_ready    <= 1'b1;
            p0_pend_rd  <= 1'b0;
            p0_pend_a   <= '0;
            p0_pend_d   <= '0;
            p1_pend_rd  <= 1'b0;
            p1_pend_a   <= '0;
            p1_pend_d   <= '0;
            p0_spo      <= '0;
            p1_spo      <= '0;
            m_a         <= '0;
            m_d         <= '0;
            m_rd        <= 1'b0;
            m_we        <= 1'b0;
            grant       <= 1'b1;
            rr_last     <= 1'b1;
            wait_first  <= 1'b0;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (done_c && !grant) begin
                p0_ready <= 1'b1;
            end else if (p0_ready && (p0_rd || p0_we)) begin
                p0_ready   <= 1'b0;
                p0_pend_rd <= p0_rd;
                p0_pend_a  <= p0_a;
                p0_pend_d  <= p0_d;
            end
            if (done_c && grant) begin
                p1_ready <= 1'b1;
            end else if (p1_ready && (p1_rd || p1_we)) begin
                p1_ready   <= 1'b0;
                p1_pend_rd <= p1_rd;
                p1_pend_a  <= p1_a;
                p1_pend_d  <= p1_d;
            end
            if (done_c && !grant && p0_pend_rd) p0_spo <= m_spo;
            if (done_c && grant && p1_pend_rd)  p1_spo <= m_spo;

            if (start_c) begin
                grant <= win_c;
                m_a   <= win_c ? p1_pend_a : p0_pend_a;
                m_d   <= win_c ? p1_pend_d : p0_pend_d;
                m_rd  <= win_c ? p1_pend_rd : p0_pend_rd;
                m_we  <= win_c ? !p1_pend_rd : !p0_pend_rd;
            end else begin
                m_rd <= 1'b0;
                m_we <= 1'b0;
            end
            if (start_c && contested_c) rr_last <= win_c;

            wait_first <= (state == ISSUE);
            if (state == WAIT) begin
                if (wait_cnt != CNT_LIMIT) wait_cnt <= wait_cnt_inc;
                if (wait_cnt_inc == CNT_LIMIT) err_timeout <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized bench for sdram_arbiter: instance 0 round-robin, instance 1 fixed priority,
// each against a latency-programmable controller model and a transaction-level reference.
module tb_sdram_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] p0_a [2];
    logic [31:0] p0_d [2];
    logic [31:0] p1_a [2];
    logic [31:0] p1_d [2];
    logic [31:0] p0_spo [2];
    logic [31:0] p1_spo [2];
    logic [31:0] m_a [2];
    logic [31:0] m_d [2];
    logic [31:0] m_spo [2];
    logic        p0_rd [2];
    logic        p0_we [2];
    logic        p1_rd [2];
    logic        p1_we [2];
    logic        p0_ready [2];
    logic        p1_ready [2];
    logic        m_rd [2];
    logic        m_we [2];
    logic        m_ready [2];
    logic        grant [2];
    logic        err_timeout [2];

    // controller model state
    logic        busy [2];
    int          lat_left [2];
    int          lat_cfg [2];
    logic        stall [2];
    logic        hang [2];
    int          n_cmd [2] = '{0, 0};
    logic [31:0] log_a [2][256];
    logic [31:0] log_d [2][256];
    logic        log_rd [2][256];
    logic        log_we [2][256];
    logic        log_g [2][256];

    // reference model state
    int          last_win [2];
    logic [31:0] exp_spo [2][2];

    int checks = 0;
    int failures = 0;

    assign m_ready[0] = !busy[0] && !stall[0];
    assign m_ready[1] = !busy[1] && !stall[1];

    sdram_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(16)) dut_rr (
        .clk(clk), .rst(rst),
        .p0_a(p0_a[0]), .p0_d(p0_d[0]), .p0_rd(p0_rd[0]), .p0_we(p0_we[0]),
        .p0_spo(p0_spo[0]), .p0_ready(p0_ready[0]),
        .p1_a(p1_a[0]), .p1_d(p1_d[0]), .p1_rd(p1_rd[0]), .p1_we(p1_we[0]),
        .p1_spo(p1_spo[0]), .p1_ready(p1_ready[0]),
        .m_a(m_a[0]), .m_d(m_d[0]), .m_rd(m_rd[0]), .m_we(m_we[0]),
        .m_spo(m_spo[0]), .m_ready(m_ready[0]),
        .grant(grant[0]), .err_timeout(err_timeout[0])
    );

    sdram_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(16)) dut_fp (
        .clk(clk), .rst(rst),
        .p0_a(p0_a[1]), .p0_d(p0_d[1]), .p0_rd(p0_rd[1]), .p0_we(p0_we[1]),
        .p0_spo(p0_spo[1]), .p0_ready(p0_ready[1]),
        .p1_a(p1_a[1]), .p1_d(p1_d[1]), .p1_rd(p1_rd[1]), .p1_we(p1_we[1]),
        .p1_spo(p1_spo[1]), .p1_ready(p1_ready[1]),
        .m_a(m_a[1]), .m_d(m_d[1]), .m_rd(m_rd[1]), .m_we(m_we[1]),
        .m_spo(m_spo[1]), .m_ready(m_ready[1]),
        .grant(grant[1]), .err_timeout(err_timeout[1])
    );

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        return (a == 32'h0000_1000) ? 32'h1234_5678 : ({a[15:0], a[31:16]} ^ 32'h5A5A_C3C3);
    endfunction

    // Controller: logs every command cycle, goes busy for lat_cfg cycles (forever when hung)
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                busy[k]     <= 1'b0;
                lat_left[k] <= 0;
                m_spo[k]    <= 32'h0;
            end else if (m_rd[k] || m_we[k]) begin
                log_a[k][n_cmd[k] % 256]  <= m_a[k];
                log_d[k][n_cmd[k] % 256]  <= m_d[k];
                log_rd[k][n_cmd[k] % 256] <= m_rd[k];
                log_we[k][n_cmd[k] % 256] <= m_we[k];
                log_g[k][n_cmd[k] % 256]  <= grant[k];
                n_cmd[k]    <= n_cmd[k] + 1;
                busy[k]     <= 1'b1;
                lat_left[k] <= lat_cfg[k];
                if (m_rd[k]) m_spo[k] <= rd_data(m_a[k]);
            end else if (busy[k] && !hang[k]) begin
                if (lat_left[k] <= 1) busy[k] <= 1'b0;
                else lat_left[k] <= lat_left[k] - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            last_win[k]   = 1;
            exp_spo[k][0] = 32'h0;
            exp_spo[k][1] = 32'h0;
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (!(p0_ready[k] && p1_ready[k]) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", {30'h0, p0_ready[k], p1_ready[k]}, 32'h3);
    endtask

    // op: 0 = read, 1 = write, 2 = read+write strobes (treated as read)
    task automatic xact(input int k, input bit u0, input bit u1, input int op0, input int op1,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input logic [31:0] a1, input logic [31:0] d1);
        int base, first, nexp, port, idx;
        bit rd;
        logic [31:0] ea, ed;
        base = n_cmd[k];
        @(negedge clk);
        if (u0) begin
            p0_a[k] = a0; p0_d[k] = d0; p0_rd[k] = (op0 != 1); p0_we[k] = (op0 != 0);
        end
        if (u1) begin
            p1_a[k] = a1; p1_d[k] = d1; p1_rd[k] = (op1 != 1); p1_we[k] = (op1 != 0);
        end
        @(negedge clk);
        p0_rd[k] = 1'b0; p0_we[k] = 1'b0; p1_rd[k] = 1'b0; p1_we[k] = 1'b0;
        if (u0 && u1) begin
            first = (k == 1) ? 0 : 1 - last_win[k];
            last_win[k] = first;
        end else begin
            first = u0 ? 0 : 1;
        end
        nexp = (u0 ? 1 : 0) + (u1 ? 1 : 0);
        wait_idle(k);
        check("cmd_count", 32'(n_cmd[k] - base), 32'(nexp));
        for (int i = 0; i < nexp; i++) begin
            port = (i == 0) ? first : 1 - first;
            idx  = (base + i) % 256;
            rd   = (port == 0) ? (op0 != 1) : (op1 != 1);
            ea   = (port == 0) ? a0 : a1;
            ed   = (port == 0) ? d0 : d1;
            check("order_grant", 32'(log_g[k][idx]), 32'(port));
            check("cmd_rd", 32'(log_rd[k][idx]), 32'(rd));
            check("cmd_we", 32'(log_we[k][idx]), 32'(!rd));
            check("cmd_a", log_a[k][idx], ea);
            if (!rd) check("cmd_d", log_d[k][idx], ed);
        end
        if (u0 && op0 != 1) exp_spo[k][0] = rd_data(a0);
        if (u1 && op1 != 1) exp_spo[k][1] = rd_data(a1);
        check("p0_spo", p0_spo[k], exp_spo[k][0]);
        check("p1_spo", p1_spo[k], exp_spo[k][1]);
    endtask

    initial begin
        int base;
        bit u0, u1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            p0_a[k] = 0; p0_d[k] = 0; p1_a[k] = 0; p1_d[k] = 0;
            p0_rd[k] = 0; p0_we[k] = 0; p1_rd[k] = 0; p1_we[k] = 0;
            stall[k] = 0; hang[k] = 0; lat_cfg[k] = 3;
        end

        for (int k = 0; k < 2; k++) begin
            do_reset();
            check("rst_p0_ready", 32'(p0_ready[k]), 32'h1);
            check("rst_p1_ready", 32'(p1_ready[k]), 32'h1);
            check("rst_p0_spo", p0_spo[k], 32'h0);
            check("rst_p1_spo", p1_spo[k], 32'h0);
            check("rst_m_a", m_a[k], 32'h0);
            check("rst_m_d", m_d[k], 32'h0);
            check("rst_m_cmd", {30'h0, m_rd[k], m_we[k]}, 32'h0);
            check("rst_grant", 32'(grant[k]), 32'h1);
            check("rst_err", 32'(err_timeout[k]), 32'h0);

            lat_cfg[k] = 8;
            xact(k, 1, 0, 0, 0, 32'h0000_1000, 32'h0, 32'h0, 32'h0);

            do_reset();
            lat_cfg[k] = 4;
            xact(k, 1, 1, 1, 0, 32'h0000_2000, 32'hAAAA_5555, 32'h0000_3000, 32'h0);
            xact(k, 1, 1, 1, 0, 32'h0000_2100, 32'h5555_AAAA, 32'h0000_3100, 32'h0);

            for (int i = 0; i < 24; i++) begin
                u0 = 1'($urandom_range(0, 1));
                u1 = 1'($urandom_range(0, 1));
                if (!u0 && !u1) u1 = 1'b1;
                lat_cfg[k] = int'($urandom_range(1, 6));
                xact(k, u0, u1, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                     $urandom, $urandom, $urandom, $urandom);
            end

            // refresh stall: request must survive m_ready=0 in IDLE
            stall[k] = 1'b1;
            base = n_cmd[k];
            @(negedge clk);
            p1_a[k] = 32'h7000_0004; p1_rd[k] = 1'b1;
            @(negedge clk);
            p1_rd[k] = 1'b0;
            repeat (400) @(negedge clk);
            check("stall_no_cmd", 32'(n_cmd[k] - base), 32'h0);
            check("stall_p1_pending", 32'(p1_ready[k]), 32'h0);
            stall[k] = 1'b0;
            wait_idle(k);
            check("stall_one_cmd", 32'(n_cmd[k] - base), 32'h1);
            exp_spo[k][1] = rd_data(32'h7000_0004);
            check("stall_p1_spo", p1_spo[k], exp_spo[k][1]);

            // strobe while busy is dropped
            lat_cfg[k] = 6;
            base = n_cmd[k];
            @(negedge clk);
            p0_a[k] = 32'h0000_4000; p0_rd[k] = 1'b1;
            @(negedge clk);
            p0_rd[k] = 1'b0;
            @(negedge clk);
            p0_a[k] = 32'h0000_5000; p0_rd[k] = 1'b1;
            @(negedge clk);
            p0_rd[k] = 1'b0;
            wait_idle(k);
            check("ignore_one_cmd", 32'(n_cmd[k] - base), 32'h1);
            check("ignore_addr", log_a[k][base % 256], 32'h0000_4000);
            exp_spo[k][0] = rd_data(32'h0000_4000);
            check("ignore_p0_spo", p0_spo[k], exp_spo[k][0]);

            // controller never answers: timeout is sticky until reset
            hang[k] = 1'b1;
            @(negedge clk);
            p0_a[k] = 32'h0000_6000; p0_rd[k] = 1'b1;
            @(negedge clk);
            p0_rd[k] = 1'b0;
            repeat (11) @(negedge clk);
            check("timeout_early", 32'(err_timeout[k]), 32'h0);
            repeat (14) @(negedge clk);
            check("timeout_set", 32'(err_timeout[k]), 32'h1);
            check("timeout_still_waiting", 32'(p0_ready[k]), 32'h0);
            repeat (20) @(negedge clk);
            check("timeout_sticky", 32'(err_timeout[k]), 32'h1);
            rst = 1'b1;
            @(negedge clk);
            check("midrst_p0_ready", 32'(p0_ready[k]), 32'h1);
            check("midrst_err", 32'(err_timeout[k]), 32'h0);
            check("midrst_p0_spo", p0_spo[k], 32'h0);
            rst = 1'b0;
            hang[k] = 1'b0;
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
